// File: rtl/array_reader.sv
`default_nettype none
// ============================================================================
//  Module      : array_reader
//  Description : Read-side sequencer for the edge-triggered array storage
//                block. Sweeps a run of consecutive indices, pulses the
//                array's get strobe once per index, captures the returned
//                word and streams it downstream over valid/ready, flagging
//                the final element of the sweep.
//  Revision    : 1.0 - initial release
// ============================================================================
module array_reader #(
   parameter int DATLEN    = 12,
   parameter int SIZE      = 64,
   parameter int SIZE_LOG2 = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic [SIZE_LOG2-1:0] start_index_i,
   input  logic [SIZE_LOG2:0]   count_i,
   input  logic                 abort_i,
   output logic                 get_o,
   output logic [SIZE_LOG2-1:0] get_index_o,
   input  logic [DATLEN-1:0]    get_val_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [DATLEN-1:0]    out_data_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 done_o
);

   // Width of the remaining-element counter: must hold the value SIZE itself.
   localparam int unsigned REM_W = SIZE_LOG2 + 1;
   localparam logic [REM_W-1:0] C_SIZE = REM_W'(SIZE);
   localparam logic [REM_W-1:0] C_ONE  = REM_W'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ISSUE   = 3'd1,
      S_CAPTURE = 3'd2,
      S_OUTPUT  = 3'd3,
      S_FINISH  = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic [SIZE_LOG2-1:0]   idx_q, idx_d;
   logic [REM_W-1:0]       rem_q, rem_d;
   logic                   get_q, get_d;
   logic [SIZE_LOG2-1:0]   get_index_q, get_index_d;
   logic                   out_valid_q, out_valid_d;
   logic                   out_last_q, out_last_d;
   logic [DATLEN-1:0]      out_data_q, out_data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;

   // Index of the element after the current one; wraps naturally because
   // SIZE is exactly 2**SIZE_LOG2.
   logic [SIZE_LOG2-1:0]   next_idx;
   // Saturated element count for an accepted start.
   logic [REM_W-1:0]       start_rem;

   assign next_idx  = idx_q + 1'b1;
   assign start_rem = (count_i > C_SIZE) ? C_SIZE : count_i;

   // Next-state and next-output computation; every output is registered so
   // the array and downstream logic see glitch-free signals.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rem_d       = rem_q;
      get_d       = 1'b0;
      get_index_d = get_index_q;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = out_data_q;
      busy_d      = 1'b1;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            // abort in IDLE wins over a simultaneous start
            if (start_i && !abort_i) begin
               busy_d = 1'b1;
               idx_d  = start_index_i;
               if (count_i == '0) begin
                  rem_d   = '0;
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end else begin
                  rem_d       = start_rem;
                  state_d     = S_ISSUE;
                  get_d       = 1'b1;
                  get_index_d = start_index_i;
               end
            end
         end

         S_ISSUE: begin
            // get drops after exactly one cycle; index stays put for capture
            state_d = S_CAPTURE;
         end

         S_CAPTURE: begin
            state_d     = S_OUTPUT;
            out_data_d  = get_val_i;
            out_valid_d = 1'b1;
            out_last_d  = (rem_q == C_ONE);
         end

         S_OUTPUT: begin
            if (out_ready_i) begin
               rem_d = rem_q - 1'b1;
               idx_d = next_idx;
               if (rem_q == C_ONE) begin
                  state_d = S_FINISH;
                  done_d  = 1'b1;
               end else begin
                  state_d     = S_ISSUE;
                  get_d       = 1'b1;
                  get_index_d = next_idx;
               end
            end else begin
               // hold the element until it is accepted
               out_valid_d = 1'b1;
               out_last_d  = out_last_q;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      // abort overrides everything outside IDLE, including a same-cycle
      // handshake; the pending element is simply dropped
      if (abort_i && (state_q != S_IDLE)) begin
         state_d     = S_IDLE;
         get_d       = 1'b0;
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
         busy_d      = 1'b0;
         done_d      = 1'b0;
      end
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         get_q       <= 1'b0;
         get_index_q <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rem_q       <= rem_d;
         get_q       <= get_d;
         get_index_q <= get_index_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign get_o       = get_q;
   assign get_index_o = get_index_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

`ifndef SYNTHESIS
   // The array needs a low phase between reads to see a fresh rising edge.
   a_get_single : assert property (@(posedge clk) disable iff (!rst_n) get_q |=> !get_q);
`endif

endmodule
`default_nettype wire

// File: tb/tb_array_reader.sv
`timescale 1ns/1ps
module tb_array_reader;

   localparam int DATLEN    = 12;
   localparam int SIZE      = 64;
   localparam int SIZE_LOG2 = 6;
   localparam int BUDGET    = 2000;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start_i = 1'b0;
   logic [SIZE_LOG2-1:0] start_index_i = '0;
   logic [SIZE_LOG2:0]   count_i = '0;
   logic                 abort_i = 1'b0;
   logic                 get_o;
   logic [SIZE_LOG2-1:0] get_index_o;
   logic [DATLEN-1:0]    get_val_i = '0;
   logic                 out_valid_o;
   logic                 out_ready_i = 1'b0;
   logic [DATLEN-1:0]    out_data_o;
   logic                 out_last_o;
   logic                 busy_o;
   logic                 done_o;

   int errors = 0;
   int checks = 0;

   logic [DATLEN-1:0] mem [SIZE];
   int get_edges = 0;
   int idx_log[$];

   array_reader #(.DATLEN(DATLEN), .SIZE(SIZE), .SIZE_LOG2(SIZE_LOG2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_i      (start_i),
      .start_index_i(start_index_i),
      .count_i      (count_i),
      .abort_i      (abort_i),
      .get_o        (get_o),
      .get_index_o  (get_index_o),
      .get_val_i    (get_val_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .out_data_o   (out_data_o),
      .out_last_o   (out_last_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   // Behavioural array: latches the addressed word on each rising edge of get.
   always @(posedge get_o) begin
      get_edges = get_edges + 1;
      #1;
      get_val_i = mem[get_index_o];
      idx_log.push_back(int'(get_index_o));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Generic sweep: mode 0 ready high, 1 random ready, 2 stall 5 cycles at first valid.
   task automatic run_sweep(input int si, input int cnt, input int mode, input bit junk_start);
      int n, cyc, first_valid, done_cyc, got, edges0, log0, stall_left, snap_edges;
      int exp_idx[$];
      logic [DATLEN-1:0] exp_dat[$];
      bit prev_get, r;
      logic [DATLEN-1:0] snap_d;
      logic [SIZE_LOG2-1:0] snap_i;
      n = (cnt > SIZE) ? SIZE : cnt;
      for (int k = 0; k < n; k++) begin
         exp_idx.push_back((si + k) % SIZE);
         exp_dat.push_back(mem[(si + k) % SIZE]);
      end
      edges0 = get_edges;
      log0 = idx_log.size();
      start_index_i = SIZE_LOG2'(si);
      count_i = (SIZE_LOG2+1)'(cnt);
      start_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      cyc = 1; first_valid = -1; done_cyc = -1; got = 0; stall_left = -1;
      prev_get = 1'b0; snap_d = '0; snap_i = '0; snap_edges = 0;
      while (done_cyc < 0 && cyc < BUDGET) begin
         if (cyc == 1) begin
            checks++;
            if (get_o !== (n != 0)) begin
               errors++; $display("FAIL get_latency: got %b expected %b", get_o, (n != 0));
            end
         end
         if (get_o) begin
            checks++;
            if (prev_get) begin
               errors++; $display("FAIL get_consecutive: get high two cycles at cyc %0d", cyc);
            end
         end
         prev_get = get_o;
         checks++;
         if (busy_o !== 1'b1) begin
            errors++; $display("FAIL busy_sweep: got %b expected 1 at cyc %0d", busy_o, cyc);
         end
         if (out_valid_o && first_valid < 0) begin
            first_valid = cyc;
            if (mode == 2) stall_left = 5;
         end
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = 1'($urandom_range(0, 1));
         else r = (stall_left > 0) ? 1'b0 : 1'b1;
         if (mode == 2 && stall_left >= 0) begin
            if (stall_left == 5) begin
               snap_d = out_data_o; snap_i = get_index_o; snap_edges = get_edges;
            end else begin
               checks++;
               if (out_valid_o !== 1'b1 || out_data_o !== snap_d || get_index_o !== snap_i
                   || get_edges != snap_edges) begin
                  errors++;
                  $display("FAIL stall_hold: got v=%b d=%h i=%0d e=%0d expected v=1 d=%h i=%0d e=%0d",
                           out_valid_o, out_data_o, get_index_o, get_edges, snap_d, snap_i, snap_edges);
               end
            end
            stall_left--;
         end
         out_ready_i = r;
         if (out_valid_o && r) begin
            checks++;
            if (got >= n) begin
               errors++; $display("FAIL extra_element: got %h beyond expected count %0d", out_data_o, n);
            end else if ({out_last_o, out_data_o} !== {(got == n - 1), exp_dat[got]}) begin
               errors++;
               $display("FAIL element[%0d]: got last=%b data=%h expected last=%b data=%h",
                        got, out_last_o, out_data_o, (got == n - 1), exp_dat[got]);
            end
            got++;
         end else if (out_valid_o) begin
            checks++;
            if (out_last_o !== (got == n - 1)) begin
               errors++; $display("FAIL last_hold: got %b expected %b", out_last_o, (got == n - 1));
            end
         end
         if (done_o) begin
            done_cyc = cyc;
            start_i = 1'b0;
         end else begin
            if (junk_start) begin
               start_i = 1'($urandom_range(0, 1));
               start_index_i = SIZE_LOG2'($urandom_range(0, SIZE - 1));
               count_i = (SIZE_LOG2+1)'($urandom_range(1, 8));
            end
            step();
            cyc++;
         end
      end
      start_i = 1'b0;
      checks++;
      if (done_cyc < 0) begin
         errors++; $display("FAIL sweep_timeout: no done within %0d cycles", BUDGET);
      end
      checks++;
      if (got != n) begin
         errors++; $display("FAIL element_count: got %0d expected %0d", got, n);
      end
      checks++;
      if (get_edges - edges0 != n) begin
         errors++; $display("FAIL get_edges: got %0d expected %0d", get_edges - edges0, n);
      end
      for (int k = 0; k < n && log0 + k < idx_log.size(); k++) begin
         checks++;
         if (idx_log[log0 + k] != exp_idx[k]) begin
            errors++; $display("FAIL get_index[%0d]: got %0d expected %0d", k, idx_log[log0 + k], exp_idx[k]);
         end
      end
      if (n > 0) begin
         checks++;
         if (first_valid != 3) begin
            errors++; $display("FAIL valid_latency: got %0d expected 3", first_valid);
         end
      end
      if (mode == 0) begin
         checks++;
         if (done_cyc != ((n == 0) ? 1 : 3 * n + 1)) begin
            errors++; $display("FAIL done_cycle: got %0d expected %0d", done_cyc, (n == 0) ? 1 : 3 * n + 1);
         end
      end
      step();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== 1'b0 || out_last_o !== 1'b0) begin
         errors++;
         $display("FAIL post_sweep: got busy=%b done=%b valid=%b last=%b expected all 0",
                  busy_o, done_o, out_valid_o, out_last_o);
      end
      out_ready_i = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step(); step();
      checks++;
      if ({get_o, out_valid_o, out_last_o, busy_o, done_o} !== 5'b0 || get_index_o !== '0 || out_data_o !== '0) begin
         errors++;
         $display("FAIL reset_state: got get=%b v=%b l=%b busy=%b done=%b idx=%0d data=%h expected all 0",
                  get_o, out_valid_o, out_last_o, busy_o, done_o, get_index_o, out_data_o);
      end
      rst_n = 1'b1;
      step();
      checks++;
      if (busy_o !== 1'b0 || get_o !== 1'b0) begin
         errors++; $display("FAIL reset_idle: got busy=%b get=%b expected 0", busy_o, get_o);
      end
   endtask

   task automatic test_basic();
      run_sweep(0, 4, 0, 1'b0);
   endtask

   task automatic test_wrap();
      run_sweep(62, 4, 0, 1'b0);
   endtask

   task automatic test_stall();
      run_sweep($urandom_range(0, SIZE - 1), 4, 2, 1'b0);
   endtask

   task automatic test_count_edges();
      run_sweep(5, 0, 0, 1'b0);
      run_sweep(17, 100, 0, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 5; t++)
         run_sweep($urandom_range(0, SIZE - 1), $urandom_range(1, 70), 1, 1'b1);
   endtask

   task automatic test_abort();
      int si, e0;
      si = $urandom_range(0, SIZE - 1);
      e0 = get_edges;
      start_index_i = SIZE_LOG2'(si);
      count_i = 7'd4;
      start_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 1; c < 6; c++) step();
      checks++;
      if (out_valid_o !== 1'b1 || out_data_o !== mem[(si + 1) % SIZE]) begin
         errors++; $display("FAIL abort_pre: got v=%b d=%h expected v=1 d=%h", out_valid_o, out_data_o, mem[(si + 1) % SIZE]);
      end
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      checks++;
      if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || get_o !== 1'b0) begin
         errors++; $display("FAIL abort_exit: got v=%b busy=%b get=%b expected 0", out_valid_o, busy_o, get_o);
      end
      for (int c = 0; c < 8; c++) begin
         checks++;
         if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_quiet: got done=%b busy=%b expected 0", done_o, busy_o);
         end
         step();
      end
      checks++;
      if (get_edges - e0 != 2) begin
         errors++; $display("FAIL abort_edges: got %0d expected 2", get_edges - e0);
      end
      out_ready_i = 1'b0;
      run_sweep($urandom_range(0, SIZE - 1), 3, 0, 1'b0);
   endtask

   task automatic test_abort_idle();
      int e0;
      e0 = get_edges;
      start_index_i = 6'd3;
      count_i = 7'd2;
      start_i = 1'b1;
      abort_i = 1'b1;
      step();
      start_i = 1'b0;
      abort_i = 1'b0;
      checks++;
      if (busy_o !== 1'b0 || get_o !== 1'b0 || done_o !== 1'b0) begin
         errors++; $display("FAIL abort_idle: got busy=%b get=%b done=%b expected 0", busy_o, get_o, done_o);
      end
      step(); step();
      checks++;
      if (get_edges != e0) begin
         errors++; $display("FAIL abort_idle_edges: got %0d expected %0d", get_edges, e0);
      end
   endtask

   task automatic test_reset_mid();
      start_index_i = 6'd9;
      count_i = 7'd4;
      start_i = 1'b1;
      out_ready_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({get_o, out_valid_o, busy_o, done_o} !== 4'b0 || out_data_o !== '0 || get_index_o !== '0) begin
         errors++;
         $display("FAIL reset_async: got get=%b v=%b busy=%b done=%b d=%h i=%0d expected all 0",
                  get_o, out_valid_o, busy_o, done_o, out_data_o, get_index_o);
      end
      step();
      rst_n = 1'b1;
      out_ready_i = 1'b0;
      step();
      checks++;
      if (busy_o !== 1'b0 || done_o !== 1'b0) begin
         errors++; $display("FAIL reset_release: got busy=%b done=%b expected 0", busy_o, done_o);
      end
      run_sweep(40, 5, 0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) mem[i] = DATLEN'($urandom_range(0, 4095));
      for (int i = 0; i < 4; i++) mem[i] = DATLEN'(12'h100 + i);
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_count_edges();
      test_random();
      test_abort();
      test_abort_idle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/array_reader.md
Name: array_reader

Overview:
- Read-side sequencer for the edge-triggered `array` storage block.
- On a start request, sweeps a run of consecutive indices and pulses the array's `get` strobe for each one.
- Captures each returned value and streams it downstream over a valid/ready handshake, flagging the last element.
- Drains sample buffers (12-bit acquisition words) to the serializer/host path.

Parameters:
- datlen, 12, width of each array element in bits.
- size, 64, number of array elements; must equal 2**size_log2.
- size_log2, 6, index width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a sweep; sampled only in IDLE.
- start_index  input  size_log2  first array index of the sweep; latched on accepted start.
- count  input  size_log2+1  number of elements to read; latched on accepted start.
- abort  input  1  terminate the sweep in progress.
- get  output  1  read strobe to the array; the array reacts to its rising edge.
- get_index  output  size_log2  index presented to the array.
- get_val  input  datlen  array read data.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts when high together with out_valid.
- out_data  output  datlen  element read from the array.
- out_last  output  1  high with out_valid on the final element of a sweep.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a sweep completes normally.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE.
  - get, out_valid, out_last, busy and done are 0.
  - get_index, out_data and the internal index/remaining counters are 0.
- States: IDLE, ISSUE, CAPTURE, OUTPUT, FINISH.
- IDLE:
  - start=1 with latched count=0 → FINISH.
  - start=1 with count≠0 → ISSUE; idx=start_index and rem=min(count,size) are latched.
  - count>size saturates to size.
- ISSUE:
  - get=1 and get_index=idx, both registered; duration one cycle; → CAPTURE.
- CAPTURE:
  - get=0, get_index held.
  - out_data is loaded from get_val at the end of this cycle; → OUTPUT.
- OUTPUT:
  - out_valid=1; out_last=1 when rem=1.
  - out_data is stable until the handshake.
  - On out_valid&out_ready: rem decrements and idx increments modulo size (wraps from size-1 to 0).
  - After the handshake: rem becomes 0 → FINISH; otherwise → ISSUE.
- FINISH:
  - done=1 for one cycle; → IDLE.
  - busy is high in FINISH.
- Latency and throughput:
  - An accepted start at clock edge N gives get high in cycle N+1.
  - out_valid first rises in cycle N+3.
  - Maximum throughput is one element per 3 cycles with out_ready held high.
- get is never high in two consecutive cycles, so the array always sees a clean rising edge per element.
- get_index is stable from ISSUE through CAPTURE.
- out_data retains its last value after the sweep; out_valid and out_last are 0 outside OUTPUT.
- start while busy=1 is ignored; no queuing.
- abort=1 in any non-IDLE state:
  - next state is IDLE; get and out_valid are forced low; done is not pulsed.
  - Dropping out_valid without a handshake is permitted only in this case.
  - abort has priority over the out_ready handshake in the same cycle.
- abort in IDLE has no effect. Simultaneous start and abort in IDLE: abort wins, start is ignored.
- Reset asserted mid-sweep returns all outputs to their reset values immediately, with no done pulse. After release the block waits in IDLE for a new start.

Test Plan:
- Reset, then start with start_index=0, count=4, array preloaded 0x100..0x103, out_ready=1 → outputs 0x100,0x101,0x102,0x103 in order; out_valid first high 3 cycles after start; out_last only with 0x103; one done pulse; 4 get rising edges.
- start_index=62, count=4, out_ready=1 → get_index sequence 62,63,0,1 (wrap); out_data follows the array contents at those indices.
- out_ready low for 5 cycles while out_valid=1 → out_data, out_valid and get_index hold; no further get edges; the sweep resumes after out_ready rises.
- count=0 → no get pulse, no out_valid, done high in the cycle after start; count=100 with size=64 → exactly 64 elements transferred.
- abort in the OUTPUT state of the 2nd of 4 elements → out_valid low the next cycle, busy=0, done never asserted; a new start is then accepted normally. Also: start while busy produces no restart.
- Assert rst_n low during CAPTURE → get, out_valid, busy and done go to 0 asynchronously; after release a fresh sweep completes correctly.
